// File: rtl/kwan_sap_pkg.sv
// rtl/kwan_sap_pkg.sv - shared opcodes, micro-step encoding and control word for the kwan_sap core
package kwan_sap_pkg;

  localparam int NUM_T = 5;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } tstate_t;

  typedef struct packed {
    logic mi;
    logic ri;
    logic ro;
    logic ii;
    logic io;
    logic ai;
    logic ao;
    logic bi;
    logic eo;
    logic su;
    logic fi;
    logic ci;
    logic co;
    logic j;
    logic jc;
    logic jz;
    logic oi;
    logic hlt;
    logic last;
  } ctrl_t;

endpackage

// File: rtl/kwan_sap_ctrl.sv
// rtl/kwan_sap_ctrl.sv - microcode decoder: (opcode, micro-step) to control word
module kwan_sap_ctrl
  import kwan_sap_pkg::*;
(
  input  logic [3:0] opcode_i,
  input  tstate_t    tstate_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (tstate_i)
      T0: begin
        ctrl_o.co = 1'b1;
        ctrl_o.mi = 1'b1;
      end
      T1: begin
        ctrl_o.ro = 1'b1;
        ctrl_o.ii = 1'b1;
        ctrl_o.ci = 1'b1;
      end
      T2: begin
        case (opcode_i)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl_o.io = 1'b1;
            ctrl_o.mi = 1'b1;
          end
          OP_LDI: begin
            ctrl_o.io   = 1'b1;
            ctrl_o.ai   = 1'b1;
            ctrl_o.last = 1'b1;
          end
          OP_JMP: begin
            ctrl_o.io   = 1'b1;
            ctrl_o.j    = 1'b1;
            ctrl_o.last = 1'b1;
          end
          OP_JC: begin
            ctrl_o.io   = 1'b1;
            ctrl_o.jc   = 1'b1;
            ctrl_o.last = 1'b1;
          end
          OP_JZ: begin
            ctrl_o.io   = 1'b1;
            ctrl_o.jz   = 1'b1;
            ctrl_o.last = 1'b1;
          end
          OP_OUT: begin
            ctrl_o.ao   = 1'b1;
            ctrl_o.oi   = 1'b1;
            ctrl_o.last = 1'b1;
          end
          OP_HLT: begin
            ctrl_o.hlt  = 1'b1;
            ctrl_o.last = 1'b1;
          end
          default: ctrl_o.last = 1'b1;
        endcase
      end
      T3: begin
        case (opcode_i)
          OP_LDA: begin
            ctrl_o.ro   = 1'b1;
            ctrl_o.ai   = 1'b1;
            ctrl_o.last = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl_o.ro = 1'b1;
            ctrl_o.bi = 1'b1;
          end
          OP_STA: begin
            ctrl_o.ao   = 1'b1;
            ctrl_o.ri   = 1'b1;
            ctrl_o.last = 1'b1;
          end
          default: ctrl_o.last = 1'b1;
        endcase
      end
      T4: begin
        ctrl_o.eo   = 1'b1;
        ctrl_o.ai   = 1'b1;
        ctrl_o.fi   = 1'b1;
        ctrl_o.su   = (opcode_i == OP_SUB);
        ctrl_o.last = 1'b1;
      end
      default: ctrl_o.last = 1'b1;
    endcase
  end

endmodule

// File: rtl/kwan_sap_core.sv
// rtl/kwan_sap_core.sv - self-sequencing accumulator CPU: PC, MAR, RAM, IR, A/B, ALU and loader port
module kwan_sap_core
  import kwan_sap_pkg::*;
#(
  parameter int BUS_SIZE = 8,
  parameter int ADR_SIZE = 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                run,
  input  logic                ld_we,
  input  logic [ADR_SIZE-1:0] ld_addr,
  input  logic [BUS_SIZE-1:0] ld_data,
  output logic [BUS_SIZE-1:0] out_val,
  output logic                out_strobe,
  output logic                halted,
  output logic [BUS_SIZE-1:0] aval,
  output logic [BUS_SIZE-1:0] bval,
  output logic [BUS_SIZE-1:0] bus,
  output logic                cf,
  output logic                zf,
  output logic [ADR_SIZE-1:0] pc,
  output logic [2:0]          tstate
);

  localparam int DEPTH = 2 ** ADR_SIZE;
  localparam int PAD   = BUS_SIZE - ADR_SIZE;
  localparam logic [ADR_SIZE-1:0] PC_ONE = 1;

  logic [ADR_SIZE-1:0] pc_q, pc_d, mar_q, mar_d;
  logic [BUS_SIZE-1:0] ir_q, ir_d, a_q, a_d, b_q, b_d, out_q, out_d;
  logic                strobe_q, strobe_d, halted_q, halted_d;
  logic                cf_q, cf_d, zf_q, zf_d;
  tstate_t             tstate_q, tstate_d;

  logic [BUS_SIZE-1:0] mem_q [DEPTH];

  ctrl_t               ctrl_raw, ctrl;
  logic                advance;
  logic [BUS_SIZE-1:0] alu_b;
  logic [BUS_SIZE:0]   alu_sum;

  kwan_sap_ctrl u_ctrl (
    .opcode_i (ir_q[BUS_SIZE-1 -: 4]),
    .tstate_i (tstate_q),
    .ctrl_o   (ctrl_raw)
  );

  // A halted core drives nothing, so the bus and all enables go quiet.
  assign ctrl    = halted_q ? '0 : ctrl_raw;
  assign advance = run && !halted_q;

  // SUB is A + ~B + 1; the carry-in comes from the su bit itself.
  assign alu_b   = ctrl.su ? ~b_q : b_q;
  assign alu_sum = {1'b0, a_q} + {1'b0, alu_b} + {{BUS_SIZE{1'b0}}, ctrl.su};

  always_comb begin
    bus = '0;
    if (ctrl.co)      bus = {{PAD{1'b0}}, pc_q};
    else if (ctrl.ro) bus = mem_q[mar_q];
    else if (ctrl.io) bus = {{PAD{1'b0}}, ir_q[ADR_SIZE-1:0]};
    else if (ctrl.ao) bus = a_q;
    else if (ctrl.eo) bus = alu_sum[BUS_SIZE-1:0];
  end

  always_comb begin
    pc_d     = pc_q;
    mar_d    = mar_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    out_d    = out_q;
    strobe_d = 1'b0;
    halted_d = halted_q;
    cf_d     = cf_q;
    zf_d     = zf_q;
    tstate_d = tstate_q;
    if (advance) begin
      if (ctrl.mi) mar_d = bus[ADR_SIZE-1:0];
      if (ctrl.ii) ir_d = bus;
      if (ctrl.ci) pc_d = pc_q + PC_ONE;
      if (ctrl.j || (ctrl.jc && cf_q) || (ctrl.jz && zf_q)) pc_d = bus[ADR_SIZE-1:0];
      if (ctrl.ai) a_d = bus;
      if (ctrl.bi) b_d = bus;
      if (ctrl.fi) begin
        cf_d = alu_sum[BUS_SIZE];
        zf_d = (alu_sum[BUS_SIZE-1:0] == '0);
      end
      if (ctrl.oi) begin
        out_d    = bus;
        strobe_d = 1'b1;
      end
      if (ctrl.hlt) halted_d = 1'b1;
      if (ctrl.last || int'(tstate_q) == NUM_T - 1) tstate_d = T0;
      else tstate_d = tstate_t'(tstate_q + 3'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pc_q     <= '0;
      mar_q    <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      out_q    <= '0;
      strobe_q <= 1'b0;
      halted_q <= 1'b0;
      cf_q     <= 1'b0;
      zf_q     <= 1'b0;
      tstate_q <= T0;
    end else begin
      pc_q     <= pc_d;
      mar_q    <= mar_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      out_q    <= out_d;
      strobe_q <= strobe_d;
      halted_q <= halted_d;
      cf_q     <= cf_d;
      zf_q     <= zf_d;
      tstate_q <= tstate_d;
    end
  end

  // The loader owns RAM only while stopped; it is deliberately not blocked by clr.
  always_ff @(posedge clk) begin
    if (!run && ld_we) mem_q[ld_addr] <= ld_data;
    else if (advance && !clr && ctrl.ri) mem_q[mar_q] <= bus;
  end

  assign out_val    = out_q;
  assign out_strobe = strobe_q;
  assign halted     = halted_q;
  assign aval       = a_q;
  assign bval       = b_q;
  assign cf         = cf_q;
  assign zf         = zf_q;
  assign pc         = pc_q;
  assign tstate     = tstate_q;

endmodule

// File: tb/tb_kwan_sap_core.sv
// tb/tb_kwan_sap_core.sv - directed self-checking bench for kwan_sap_core
module tb_kwan_sap_core;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       run = 1'b0;
  logic       ld_we = 1'b0;
  logic [3:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  logic [7:0] out_val, aval, bval, bus;
  logic       out_strobe, halted, cf, zf;
  logic [3:0] pc;
  logic [2:0] tstate;

  int n_pass  = 0;
  int n_total = 0;
  int strobes = 0;
  int pc_exp [7] = '{0, 1, 15, 15, 0, 0, 0};

  kwan_sap_core #(.BUS_SIZE(8), .ADR_SIZE(4)) dut (
    .clk        (clk),
    .clr        (clr),
    .run        (run),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .out_val    (out_val),
    .out_strobe (out_strobe),
    .halted     (halted),
    .aval       (aval),
    .bval       (bval),
    .bus        (bus),
    .cf         (cf),
    .zf         (zf),
    .pc         (pc),
    .tstate     (tstate)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    ld_addr = a;
    ld_data = d;
    ld_we   = 1'b1;
    step();
    ld_we   = 1'b0;
  endtask

  task automatic hold_reset();
    clr = 1'b1;
    run = 1'b0;
    step();
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 16; i++) wr(4'(i), 8'h00);
  endtask

  task automatic load_prog1();
    clear_ram();
    wr(4'd0, 8'h1E);
    wr(4'd1, 8'h2F);
    wr(4'd2, 8'hE0);
    wr(4'd3, 8'hF0);
    wr(4'd14, 8'h1C);
    wr(4'd15, 8'h0E);
  endtask

  task automatic release_core();
    clr = 1'b0;
    run = 1'b1;
  endtask

  task automatic run_to_halt(input string tag, output int n_strobe);
    int n = 0;
    n_strobe = 0;
    while (!halted && n < 80) begin
      step();
      n++;
      if (out_strobe) n_strobe++;
    end
    chk(tag, halted, 1);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_tstate"}, tstate, 0);
    chk({tag, "_a"}, aval, 0);
    chk({tag, "_b"}, bval, 0);
    chk({tag, "_out"}, out_val, 0);
    chk({tag, "_strobe"}, out_strobe, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_cf"}, cf, 0);
    chk({tag, "_zf"}, zf, 0);
    chk({tag, "_bus"}, bus, 0);
  endtask

  initial begin
    // Reset state
    hold_reset();
    step();
    chk_cleared("rst");

    // Test 1: LDA 14; ADD 15; OUT; HLT -> 1C + 0E = 2A
    load_prog1();
    release_core();
    for (int c = 1; c <= 20; c++) begin
      step();
      chk($sformatf("t1_strobe_c%0d", c), out_strobe, (c == 12));
      chk($sformatf("t1_halted_c%0d", c), halted, (c >= 15));
    end
    chk("t1_out", out_val, 8'h2A);
    chk("t1_a", aval, 8'h2A);
    chk("t1_pc", pc, 4);
    chk("t1_cf", cf, 0);
    chk("t1_zf", zf, 0);
    chk("t1_tstate", tstate, 0);

    // Test 2: 7 - 7 = 0 sets zf and cf, JZ 6 taken, OUT 00, HLT at 7
    hold_reset();
    clear_ram();
    wr(4'd0, 8'h1E);
    wr(4'd1, 8'h3F);
    wr(4'd2, 8'h86);
    wr(4'd3, 8'hF0);
    wr(4'd6, 8'hE0);
    wr(4'd7, 8'hF0);
    wr(4'd14, 8'h07);
    wr(4'd15, 8'h07);
    release_core();
    run_to_halt("t2_halt", strobes);
    chk("t2_a", aval, 8'h00);
    chk("t2_zf", zf, 1);
    chk("t2_cf", cf, 1);
    chk("t2_pc", pc, 8);
    chk("t2_out", out_val, 8'h00);
    chk("t2_strobes", strobes, 1);

    // Test 3: FF + 01 wraps to 00 with carry; JC 5 taken, JZ 8 taken
    hold_reset();
    clear_ram();
    wr(4'd0, 8'h1E);
    wr(4'd1, 8'h2F);
    wr(4'd2, 8'h75);
    wr(4'd3, 8'hF0);
    wr(4'd5, 8'h88);
    wr(4'd6, 8'hF0);
    wr(4'd8, 8'hF0);
    wr(4'd14, 8'hFF);
    wr(4'd15, 8'h01);
    release_core();
    run_to_halt("t3_halt", strobes);
    chk("t3_a", aval, 8'h00);
    chk("t3_cf", cf, 1);
    chk("t3_zf", zf, 1);
    chk("t3_pc", pc, 9);

    // Test 4: JMP 15 then NOP at 15, pc wraps to 0
    hold_reset();
    clear_ram();
    wr(4'd0, 8'h6F);
    release_core();
    for (int c = 1; c <= 7; c++) begin
      step();
      chk($sformatf("t4_pc_c%0d", c), pc, pc_exp[c-1]);
    end
    chk("t4_tstate", tstate, 1);
    chk("t4_refetch_bus", bus, 8'h6F);

    // Test 5: pause at ADD T3, load RAM[14] while stopped, ignored load while running
    hold_reset();
    load_prog1();
    release_core();
    for (int c = 1; c <= 7; c++) step();
    chk("t5_at_t3", tstate, 3);
    run = 1'b0;
    ld_addr = 4'd14;
    ld_data = 8'h55;
    ld_we = 1'b1;
    step();
    ld_we = 1'b0;
    for (int c = 0; c < 4; c++) step();
    chk("t5_hold_tstate", tstate, 3);
    chk("t5_hold_pc", pc, 2);
    chk("t5_hold_a", aval, 8'h1C);
    chk("t5_hold_b", bval, 8'h00);
    run = 1'b1;
    ld_addr = 4'd14;
    ld_data = 8'h99;
    ld_we = 1'b1;
    step();
    ld_we = 1'b0;
    chk("t5_resume_b", bval, 8'h0E);
    run_to_halt("t5_halt", strobes);
    chk("t5_out", out_val, 8'h2A);
    hold_reset();
    wr(4'd1, 8'hE0);
    wr(4'd2, 8'hF0);
    release_core();
    run_to_halt("t5_readback_halt", strobes);
    chk("t5_ram14", out_val, 8'h55);

    // Test 6: clr at LDA T3 and while halted
    hold_reset();
    load_prog1();
    release_core();
    for (int c = 1; c <= 3; c++) step();
    chk("t6_at_t3", tstate, 3);
    chk("t6_pc_before", pc, 1);
    clr = 1'b1;
    step();
    chk_cleared("t6_mid");
    clr = 1'b0;
    run_to_halt("t6_halt1", strobes);
    chk("t6_out1", out_val, 8'h2A);
    clr = 1'b1;
    step();
    chk_cleared("t6_hlt");
    clr = 1'b0;
    run_to_halt("t6_halt2", strobes);
    chk("t6_out2", out_val, 8'h2A);
    chk("t6_pc2", pc, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
